ext_interleaver: RTL and testbench
==================================

Name: ext_interleaver

Overview:
- Sits between two Siso decoder instances in the iterative turbo loop.
- Collects one frame of 84-bit extrinsic words (7 lanes x 12-bit signed LLR) from a Siso data_o/finish stream into a ping-pong buffer.
- Permutes the frame at LLR granularity: interleave for the Siso1 path, deinterleave for the Siso0 path.
- Streams the permuted frame out word-by-word as the ext_i feed for the next Siso.

Parameters:
- LLR_W, 12, bits per signed LLR.
- LANES, 7, LLRs per word.
- WORDS, 5, words per frame. K = LANES*WORDS = 35 is a derived localparam.
- STEP, 12, interleaver multiplier. gcd(STEP,K) must be 1; elaboration-time check errors otherwise.
- OFFSET, 0, interleaver offset, 0 <= OFFSET < K.

Ports:
- clk_i, input, 1, clock, rising edge.
- reset_n_i, input, 1, asynchronous active-low reset.
- mode_i, input, 1, 0 = interleave, 1 = deinterleave. Sampled on the first accepted word of each frame.
- in_valid_i, input, 1, input word valid; driven from Siso finish.
- in_ready_o, output, 1, block can accept a word.
- in_data_i, input, LANES*LLR_W (84), extrinsic word. Lane l occupies bits [l*LLR_W +: LLR_W].
- out_valid_o, output, 1, output word valid.
- out_ready_i, input, 1, consumer accepts the word.
- out_data_o, output, LANES*LLR_W (84), permuted word, same lane packing.
- out_last_o, output, 1, high with the final word (word WORDS-1) of a frame.
- frame_done_o, output, 1, one-cycle pulse after the last output handshake of a frame.

Behaviour:
- Indexing: LLR index i = word*LANES + lane. Permutation pi(i) = (STEP*i + OFFSET) mod K.
- Interleave (mode 0): out[pi(i)] = in[i]. Implemented by scatter writes to bank address pi(i) and linear reads.
- Deinterleave (mode 1): out[j] = in[pi(j)]. Implemented by linear writes and gather reads from bank address pi(j).
- Deinterleave(interleave(x)) = x bit-exactly. LLR values pass through unmodified: no saturation, no sign change.
- Addresses are generated incrementally with mod-K add chains. No runtime divider; no multiplier on the datapath.
- Two banks, each K x LLR_W flops. Each bank has its own latched mode and a state:
  - EMPTY -> FILLING on the first input handshake.
  - FILLING -> FULL on the WORDS-th input handshake.
  - FULL -> DRAINING when selected as the read bank.
  - DRAINING -> EMPTY on the last output handshake.
- Write pointer and read pointer each toggle bank on frame completion. Banks are filled and drained in strict order.
- in_ready_o = 1 when the write bank is EMPTY or FILLING.
- A handshake is valid & ready. An input word with in_valid_i=1 while in_ready_o=0 is ignored; upstream holds it.
- Latency: out_valid_o rises the cycle after the last input handshake of a frame, provided the other bank is not DRAINING.
- With out_ready_i held at 1, a frame drains in exactly WORDS consecutive cycles.
- out_data_o is registered. It holds stable while out_valid_o=1 and out_ready_i=0.
- Simultaneous events:
  - A write into one bank and a read from the other in the same cycle are both served.
  - The last output handshake of bank A and the last input handshake of bank B in the same cycle: A goes EMPTY, B goes FULL, and out_valid_o stays 1 next cycle with B's word 0 (no bubble).
- Both banks FULL/DRAINING: in_ready_o = 0 until a bank is freed.
- mode_i changes mid-frame are ignored until the next frame start.
- Reset:
  - Any time, including mid-frame, reset forces both banks EMPTY, all pointers to 0, in_ready_o=1, out_valid_o=0, out_last_o=0, frame_done_o=0, out_data_o=0.
  - Partial frames are discarded.
  - Bank contents need not be cleared.

Test Plan:
- Reset then interleave, input LLR i = i, out_ready_i=1 -> word0 lanes = 0,3,6,9,12,15,18 (pi^-1(j) = 3j mod 35). out_valid_o first high 1 cycle after the 5th input handshake. out_last_o on word 4. frame_done_o pulses once.
- Deinterleave, same input -> word0 lanes = 0,12,24,1,13,25,2. Word4 lane6 = 23.
- Interleave frame, feed the output back in deinterleave mode -> the original ramp 0..34 is recovered exactly. Repeat with all lanes = 12'hFFF (-1) and 12'h800 -> values unchanged.
- Stream three back-to-back frames with out_ready_i=0 -> in_ready_o drops after 10 words. Then set out_ready_i=1 -> 15 outputs with no bubble at frame boundaries, and out_data_o stable during the stalls.
- Random in_valid_i/out_ready_i patterns, alternating mode per frame -> output matches a scoreboard model with zero mismatches over 100 frames.
- Assert reset_n_i low after the 3rd input word of a frame -> outputs reach reset values immediately. The next full frame is processed correctly with no residue from the partial frame.

Source files
------------

// File: rtl/ext_interleaver.sv
// Ping-pong LLR interleaver/deinterleaver between two Siso decoders.
// Collects a frame of LANES-wide words and streams out the permuted frame.
module ext_interleaver #(
  parameter int LLR_W  = 12,
  parameter int LANES  = 7,
  parameter int WORDS  = 5,
  parameter int STEP   = 12,
  parameter int OFFSET = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   mode_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [LANES*LLR_W-1:0] in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [LANES*LLR_W-1:0] out_data_o,
  output logic                   out_last_o,
  output logic                   frame_done_o
);

  localparam int K  = LANES * WORDS;
  localparam int AW = $clog2(K);
  localparam int CW = $clog2(WORDS + 1);
  localparam int DW = LANES * LLR_W;
  localparam logic [AW-1:0] STEP_W  = AW'((STEP * LANES) % K);
  localparam logic [AW-1:0] OFF     = AW'(OFFSET);
  localparam logic [AW-1:0] LANES_A = AW'(LANES);

  function automatic int gcd_f(input int a, input int b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic [AW-1:0] add_mod(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (AW+1)'(K)) s = s - (AW+1)'(K);
    else                 s = s;
    return s[AW-1:0];
  endfunction

  if (gcd_f(STEP, K) != 1) begin : g_bad_step
    $error("ext_interleaver: STEP must be coprime with LANES*WORDS");
  end
  if (OFFSET < 0 || OFFSET >= K) begin : g_bad_offset
    $error("ext_interleaver: OFFSET must lie in [0, LANES*WORDS)");
  end

  typedef enum logic [1:0] {
    B_EMPTY    = 2'd0,
    B_FILLING  = 2'd1,
    B_FULL     = 2'd2,
    B_DRAINING = 2'd3
  } bank_st_t;

  bank_st_t          r_st [2];
  bank_st_t          w_st_nxt [2];
  logic              r_mode [2];
  logic [LLR_W-1:0]  r_bank [2][K];
  logic              r_wr_sel, r_ld_sel, r_out_bank;
  logic [CW-1:0]     r_wr_cnt, r_ld_cnt;
  logic [AW-1:0]     r_wr_lin, r_wr_pi, r_ld_lin, r_ld_pi;
  logic              r_out_valid, r_out_last, r_frame_done;
  logic [DW-1:0]     r_out_data;

  logic              w_in_fire, w_in_last, w_out_fire, w_out_end;
  logic              w_slot, w_src_ok, w_load, w_wr_mode, w_rd_mode;
  logic [AW-1:0]     w_waddr [LANES];
  logic [AW-1:0]     w_raddr [LANES];
  logic [DW-1:0]     w_rd_word;

  assign in_ready_o = (r_st[r_wr_sel] == B_EMPTY) || (r_st[r_wr_sel] == B_FILLING);
  assign w_in_fire  = in_valid_i && in_ready_o;
  assign w_in_last  = w_in_fire && (r_wr_cnt == CW'(WORDS - 1));
  assign w_out_fire = r_out_valid && out_ready_i;
  assign w_out_end  = w_out_fire && r_out_last;
  assign w_slot     = !r_out_valid || out_ready_i;
  assign w_load     = w_slot && w_src_ok;
  assign w_wr_mode  = (r_wr_cnt == CW'(0)) ? mode_i : r_mode[r_wr_sel];
  assign w_rd_mode  = r_mode[r_ld_sel];

  // Lane l of a word sits STEP*l past the word's base in permuted order.
  for (genvar l = 0; l < LANES; l++) begin : g_addr
    localparam logic [AW-1:0] PI_OFS = AW'((STEP * l) % K);
    assign w_waddr[l] = w_wr_mode ? (r_wr_lin + AW'(l)) : add_mod(r_wr_pi, PI_OFS);
    assign w_raddr[l] = w_rd_mode ? add_mod(r_ld_pi, PI_OFS) : (r_ld_lin + AW'(l));
  end

  // Word 0 may be loaded on the same edge the frame completes, so a
  // bank source must be ready at word 0 or already draining after that.
  always_comb begin
    if (r_ld_cnt == CW'(0)) begin
      w_src_ok = (r_st[r_ld_sel] == B_FULL) || (w_in_last && (r_wr_sel == r_ld_sel));
    end else begin
      w_src_ok = (r_st[r_ld_sel] == B_DRAINING);
    end
  end

  // Bank next-state: fill, complete, start draining, free.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_st_nxt[b] = r_st[b];
      if (w_load && (r_ld_cnt == CW'(0)) && (r_ld_sel == 1'(b))) begin
        w_st_nxt[b] = B_DRAINING;
      end else begin
        case (r_st[b])
          B_EMPTY:    w_st_nxt[b] = (w_in_fire && r_wr_sel == 1'(b)) ?
                                    (w_in_last ? B_FULL : B_FILLING) : B_EMPTY;
          B_FILLING:  w_st_nxt[b] = (w_in_last && r_wr_sel == 1'(b)) ? B_FULL : B_FILLING;
          B_FULL:     w_st_nxt[b] = B_FULL;
          B_DRAINING: w_st_nxt[b] = (w_out_end && r_out_bank == 1'(b)) ? B_EMPTY : B_DRAINING;
          default:    w_st_nxt[b] = B_EMPTY;
        endcase
      end
    end
  end

  // Read word with forwarding of lanes written on this very edge.
  always_comb begin
    logic [LLR_W-1:0] v_lane;
    w_rd_word = '0;
    for (int l = 0; l < LANES; l++) begin
      v_lane = r_bank[r_ld_sel][w_raddr[l]];
      for (int m = 0; m < LANES; m++) begin
        v_lane = (w_in_fire && (r_wr_sel == r_ld_sel) && (w_waddr[m] == w_raddr[l])) ?
                 in_data_i[m*LLR_W +: LLR_W] : v_lane;
      end
      w_rd_word[l*LLR_W +: LLR_W] = v_lane;
    end
  end

  // Bank storage, never reset.
  always_ff @(posedge clk_i) begin
    if (w_in_fire) begin
      for (int l = 0; l < LANES; l++) begin
        r_bank[r_wr_sel][w_waddr[l]] <= in_data_i[l*LLR_W +: LLR_W];
      end
    end
  end

  // Bank states, pointers and registered output stage.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_st[0]      <= B_EMPTY;
      r_st[1]      <= B_EMPTY;
      r_mode[0]    <= 1'b0;
      r_mode[1]    <= 1'b0;
      r_wr_sel     <= 1'b0;
      r_wr_cnt     <= CW'(0);
      r_wr_lin     <= AW'(0);
      r_wr_pi      <= OFF;
      r_ld_sel     <= 1'b0;
      r_ld_cnt     <= CW'(0);
      r_ld_lin     <= AW'(0);
      r_ld_pi      <= OFF;
      r_out_bank   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_data   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_st[0]      <= w_st_nxt[0];
      r_st[1]      <= w_st_nxt[1];
      r_frame_done <= w_out_end;
      if (w_in_fire) begin
        if (r_wr_cnt == CW'(0)) r_mode[r_wr_sel] <= mode_i;
        if (w_in_last) begin
          r_wr_cnt <= CW'(0);
          r_wr_lin <= AW'(0);
          r_wr_pi  <= OFF;
          r_wr_sel <= ~r_wr_sel;
        end else begin
          r_wr_cnt <= r_wr_cnt + CW'(1);
          r_wr_lin <= r_wr_lin + LANES_A;
          r_wr_pi  <= add_mod(r_wr_pi, STEP_W);
        end
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_rd_word;
        r_out_last  <= (r_ld_cnt == CW'(WORDS - 1));
        r_out_bank  <= r_ld_sel;
        if (r_ld_cnt == CW'(WORDS - 1)) begin
          r_ld_cnt <= CW'(0);
          r_ld_lin <= AW'(0);
          r_ld_pi  <= OFF;
          r_ld_sel <= ~r_ld_sel;
        end else begin
          r_ld_cnt <= r_ld_cnt + CW'(1);
          r_ld_lin <= r_ld_lin + LANES_A;
          r_ld_pi  <= add_mod(r_ld_pi, STEP_W);
        end
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign out_valid_o  = r_out_valid;
  assign out_data_o   = r_out_data;
  assign out_last_o   = r_out_last;
  assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_ext_interleaver.sv
// Self-checking bench for ext_interleaver: directed frames plus random
// handshakes, compared against a frame-level permutation model.
module tb_ext_interleaver;
  localparam int LLR_W = 12, LANES = 7, WORDS = 5, STEP = 12, OFFSET = 0;
  localparam int K = LANES * WORDS, DW = LANES * LLR_W;

  logic          clk_i = 1'b0;
  logic          reset_n_i, mode_i, in_valid_i, in_ready_o;
  logic [DW-1:0] in_data_i, out_data_o;
  logic          out_valid_o, out_ready_i, out_last_o, frame_done_o;

  ext_interleaver #(.LLR_W(LLR_W), .LANES(LANES), .WORDS(WORDS), .STEP(STEP), .OFFSET(OFFSET)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .mode_i(mode_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .frame_done_o(frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0, n_fail = 0, done_pulses = 0;
  logic [DW-1:0]    q_src[$];
  bit               q_srcm[$];
  logic [DW-1:0]    q_exp[$];
  bit               q_expl[$];
  logic [DW-1:0]    q_got[$];
  logic [LLR_W-1:0] m_llr [K];
  int               m_cnt = 0;
  bit               m_mode = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame model: out[pi(i)] = in[i] when interleaving, out[j] = in[pi(j)] otherwise.
  task automatic model_push(input logic [DW-1:0] w, input bit md);
    logic [LLR_W-1:0] o [K];
    logic [DW-1:0]    ow;
    int p;
    if (m_cnt == 0) m_mode = md;
    for (int l = 0; l < LANES; l++) m_llr[m_cnt*LANES + l] = w[l*LLR_W +: LLR_W];
    m_cnt++;
    if (m_cnt == WORDS) begin
      for (int i = 0; i < K; i++) begin
        p = (STEP * i + OFFSET) % K;
        if (!m_mode) o[p] = m_llr[i];
        else         o[i] = m_llr[p];
      end
      for (int wd = 0; wd < WORDS; wd++) begin
        for (int l = 0; l < LANES; l++) ow[l*LLR_W +: LLR_W] = o[wd*LANES + l];
        q_exp.push_back(ow);
        q_expl.push_back(wd == WORDS - 1);
      end
      m_cnt = 0;
    end
  endtask

  function automatic logic [DW-1:0] ramp_word(input int wd, input int base);
    logic [DW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*LLR_W +: LLR_W] = LLR_W'(base + wd*LANES + l);
    return r;
  endfunction

  function automatic logic [DW-1:0] pack(input int v [LANES]);
    logic [DW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*LLR_W +: LLR_W] = LLR_W'(v[l]);
    return r;
  endfunction

  // Only the first word's mode counts; later words carry random mode bits.
  task automatic add_word(input logic [DW-1:0] w, input int wd, input bit md);
    q_src.push_back(w);
    q_srcm.push_back((wd == 0) ? md : 1'($urandom_range(0, 1)));
  endtask

  task automatic add_ramp(input bit md, input int base);
    for (int wd = 0; wd < WORDS; wd++) add_word(ramp_word(wd, base), wd, md);
  endtask

  task automatic add_const(input logic [LLR_W-1:0] c, input bit md);
    for (int wd = 0; wd < WORDS; wd++) add_word({LANES{c}}, wd, md);
  endtask

  task automatic add_rand(input bit md);
    logic [DW-1:0] w;
    for (int wd = 0; wd < WORDS; wd++) begin
      for (int l = 0; l < LANES; l++) w[l*LLR_W +: LLR_W] = LLR_W'($urandom);
      add_word(w, wd, md);
    end
  endtask

  // One clock: drive at negedge, score handshakes, then check the next negedge.
  task automatic tick(input bit offer, input bit rdy);
    bit in_f, out_f, stall, exp_done;
    logic [DW-1:0] held;
    in_valid_i  = offer && (q_src.size() > 0);
    in_data_i   = '0;
    mode_i      = 1'b0;
    if (in_valid_i) begin
      in_data_i = q_src[0];
      mode_i    = q_srcm[0];
    end
    out_ready_i = rdy;
    #1;
    in_f  = in_valid_i && in_ready_o;
    out_f = out_valid_o && out_ready_i;
    stall = out_valid_o && !out_ready_i;
    held  = out_data_o;
    exp_done = 1'b0;
    if (out_f) begin
      if (q_exp.size() == 0) begin
        chk("spurious_out", DW'(out_valid_o), DW'(0));
      end else begin
        chk("out_data", out_data_o, q_exp[0]);
        chk("out_last", DW'(out_last_o), DW'(q_expl[0]));
        exp_done = q_expl[0];
        q_got.push_back(out_data_o);
        void'(q_exp.pop_front());
        void'(q_expl.pop_front());
      end
    end
    if (in_f) begin
      model_push(q_src[0], q_srcm[0]);
      void'(q_src.pop_front());
      void'(q_srcm.pop_front());
    end
    @(negedge clk_i);
    chk("frame_done", DW'(frame_done_o), DW'(exp_done));
    done_pulses += int'(frame_done_o);
    if (stall) begin
      chk("stall_valid", DW'(out_valid_o), DW'(1));
      chk("stall_data", out_data_o, held);
    end
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while (q_exp.size() > 0 && c < budget) begin
      tick(1'b0, 1'b1);
      c++;
    end
    chk("drain_timeout", DW'(q_exp.size()), DW'(0));
  endtask

  task automatic run_all(input int budget);
    int c = 0;
    while ((q_src.size() > 0 || q_exp.size() > 0 || out_valid_o) && c < budget) begin
      tick(1'b1, 1'b1);
      c++;
    end
    chk("run_timeout", DW'(c < budget), DW'(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, DW'(in_ready_o), DW'(1));
    chk({tag, "_out_valid"}, DW'(out_valid_o), DW'(0));
    chk({tag, "_out_last"}, DW'(out_last_o), DW'(0));
    chk({tag, "_frame_done"}, DW'(frame_done_o), DW'(0));
    chk({tag, "_out_data"}, out_data_o, DW'(0));
  endtask

  initial begin
    int e [LANES];
    int acc, nt, done0;
    logic [DW-1:0] tmp;
    logic [LLR_W-1:0] cv;

    reset_n_i = 1'b0; mode_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1 chk_reset_outputs("rst");
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    // Interleave ramp: latency, word 0 contents, single done pulse.
    done_pulses = 0;
    add_ramp(1'b0, 0);
    repeat (4) tick(1'b1, 1'b1);
    chk("lat_before", DW'(out_valid_o), DW'(0));
    tick(1'b1, 1'b1);
    chk("lat_after", DW'(out_valid_o), DW'(1));
    drain(50);
    tick(1'b0, 1'b1);
    e = '{0, 3, 6, 9, 12, 15, 18};
    chk("il_word0", q_got[0], pack(e));
    chk("il_done_once", DW'(done_pulses), DW'(1));

    // Deinterleave ramp.
    q_got.delete();
    add_ramp(1'b1, 0);
    repeat (5) tick(1'b1, 1'b1);
    drain(50);
    e = '{0, 12, 24, 1, 13, 25, 2};
    chk("dil_word0", q_got[0], pack(e));
    tmp = q_got[4];
    chk("dil_w4_l6", DW'(tmp[6*LLR_W +: LLR_W]), DW'(23));

    // Round trip restores the ramp.
    q_got.delete();
    add_ramp(1'b0, 0);
    run_all(100);
    for (int wd = 0; wd < WORDS; wd++) add_word(q_got[wd], wd, 1'b1);
    q_got.delete();
    run_all(100);
    for (int wd = 0; wd < WORDS; wd++) chk("roundtrip", q_got[wd], ramp_word(wd, 0));

    // Extreme values pass through untouched in both directions.
    for (int k = 0; k < 2; k++) begin
      cv = (k == 0) ? 12'hFFF : 12'h800;
      q_got.delete();
      add_const(cv, 1'b0);
      add_const(cv, 1'b1);
      run_all(100);
      for (int wd = 0; wd < 2*WORDS; wd++) chk("const_llr", q_got[wd], {LANES{cv}});
    end

    // Three frames against a stalled consumer, then release.
    q_got.delete();
    add_ramp(1'b0, 40);
    add_rand(1'b1);
    add_rand(1'b0);
    repeat (20) tick(1'b1, 1'b0);
    acc = 3*WORDS - q_src.size();
    chk("stall_accepted", DW'(acc), DW'(10));
    chk("stall_in_ready", DW'(in_ready_o), DW'(0));
    nt = 0;
    while (q_got.size() < 3*WORDS && nt < 40) begin
      tick(1'b1, 1'b1);
      nt++;
    end
    chk("no_bubble_cycles", DW'(nt), DW'(15));
    drain(20);

    // Random handshakes, alternating mode, 100 frames.
    done0 = done_pulses;
    for (int f = 0; f < 100; f++) add_rand(f[0]);
    nt = 0;
    while ((q_src.size() > 0 || q_exp.size() > 0 || out_valid_o) && nt < 20000) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      nt++;
    end
    chk("rand_timeout", DW'(nt < 20000), DW'(1));
    chk("rand_frames", DW'(done_pulses - done0), DW'(100));

    // Reset after three words of a frame, then a clean frame.
    add_ramp(1'b0, 0);
    repeat (3) tick(1'b1, 1'b1);
    reset_n_i = 1'b0;
    in_valid_i = 1'b0;
    #1 chk_reset_outputs("midrst");
    q_src.delete();
    q_srcm.delete();
    m_cnt = 0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    q_got.delete();
    add_ramp(1'b0, 200);
    run_all(100);
    e = '{200, 203, 206, 209, 212, 215, 218};
    chk("post_rst_word0", q_got[0], pack(e));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
